// File: rtl/cmsdk_fpga_sram_ext_if.sv
// Bus interface for cmsdk_fpga_sram_ext.
// The master drives the address, write data, byte enables and chip select.
// The slave (the SRAM) returns read data, read-valid, busy and parity error.
interface cmsdk_fpga_sram_ext_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  localparam int NB = DW / 8;

  logic [AW-1:0] ADDR;
  logic [DW-1:0] WDATA;
  logic [NB-1:0] WREN;
  logic          CS;
  logic [DW-1:0] RDATA;
  logic          RVALID;
  logic          BUSY;
  logic [NB-1:0] PERR;

  modport master (
    output ADDR, WDATA, WREN, CS,
    input  RDATA, RVALID, BUSY, PERR
  );

  modport slave (
    input  ADDR, WDATA, WREN, CS,
    output RDATA, RVALID, BUSY, PERR
  );
endinterface

// File: rtl/cmsdk_fpga_sram_ext.sv
// FPGA block-RAM SRAM with the following features:
//   - byte-lane write strobes
//   - 1- or 2-cycle pipelined reads, selected by OREG
//   - zero-fill of the whole array after reset, selected by INIT_CLEAR
//   - a read-valid strobe
// Optional feature macro: CMSDK_FPGA_SRAM_PARITY_EN.
//   - When defined, the array stores one even-parity bit per byte lane.
//   - PERR then flags lanes whose stored parity does not match the data.
//   - When undefined, PERR is always 0.
// A read that coincides with a write to the same address returns the new
// bytes for the written lanes and the old bytes for the others.
module cmsdk_fpga_sram_ext #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int OREG       = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  cmsdk_fpga_sram_ext_if.slave   bus
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Even parity of each byte lane.
  function automatic logic [NB-1:0] lane_parity(input logic [DW-1:0] d);
    logic [NB-1:0] p;
    p = {NB{1'b0}};
    for (int i = 0; i < NB; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

  logic [DW-1:0] mem_r [DEPTH];
`ifdef CMSDK_FPGA_SRAM_PARITY_EN
  logic [NB-1:0] par_r [DEPTH];
  logic [NB-1:0] wr_par_s;
  logic [NB-1:0] rd_par_s;
`endif

  state_e        state_r;
  state_e        state_nx_s;
  logic [AW-1:0] cnt_r;
  logic [AW-1:0] cnt_nx_s;
  logic          fill_we_s;
  logic          acc_s;
  logic [NB-1:0] wr_en_s;
  logic [DW-1:0] rd_word_s;
  logic [NB-1:0] rd_perr_s;

  logic          v1_r;
  logic [DW-1:0] d1_r;
  logic [NB-1:0] p1_r;

  // Fill sequencer state and word counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= (INIT_CLEAR != 0) ? ST_FILL : ST_RUN;
      cnt_r   <= {AW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next state: one word per cycle, stop after the last word (no wrap-around restart).
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    fill_we_s  = 1'b0;
    case (state_r)
      ST_FILL: begin
        fill_we_s = ~RST;
        cnt_nx_s  = cnt_r + AW'(1);
        if (cnt_r == {AW{1'b1}}) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_FILL;
        end
      end
      ST_RUN: begin
        state_nx_s = ST_RUN;
      end
      default: begin
        state_nx_s = ST_RUN;
      end
    endcase
  end

  // User accesses are only honoured in RUN and outside reset.
  // Gating with CS also kills any X on WREN.
  always_comb begin
    acc_s   = (state_r == ST_RUN) & ~RST & bus.CS;
    wr_en_s = {NB{acc_s}} & bus.WREN;
  end

`ifdef CMSDK_FPGA_SRAM_PARITY_EN
  // Parity of the incoming write data, one bit per lane.
  always_comb begin
    wr_par_s = lane_parity(bus.WDATA);
  end
`endif

  // Array update: zero-fill has priority; otherwise byte-lane user writes.
  always_ff @(posedge CLK) begin
    if (fill_we_s) begin
      mem_r[cnt_r] <= {DW{1'b0}};
`ifdef CMSDK_FPGA_SRAM_PARITY_EN
      par_r[cnt_r] <= {NB{1'b0}};
`endif
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_en_s[i]) begin
          mem_r[bus.ADDR][8*i +: 8] <= bus.WDATA[8*i +: 8];
`ifdef CMSDK_FPGA_SRAM_PARITY_EN
          par_r[bus.ADDR][i] <= wr_par_s[i];
`endif
        end
      end
    end
  end

  // Read word with write-first merge of the lanes written this cycle, and its parity check.
  always_comb begin
    rd_word_s = mem_r[bus.ADDR];
`ifdef CMSDK_FPGA_SRAM_PARITY_EN
    rd_par_s  = par_r[bus.ADDR];
`endif
    for (int i = 0; i < NB; i++) begin
      if (wr_en_s[i]) begin
        rd_word_s[8*i +: 8] = bus.WDATA[8*i +: 8];
`ifdef CMSDK_FPGA_SRAM_PARITY_EN
        rd_par_s[i] = wr_par_s[i];
`endif
      end else begin
        rd_word_s[8*i +: 8] = rd_word_s[8*i +: 8];
      end
    end
`ifdef CMSDK_FPGA_SRAM_PARITY_EN
    rd_perr_s = lane_parity(rd_word_s) ^ rd_par_s;
`else
    rd_perr_s = {NB{1'b0}};
`endif
  end

  // First read stage: data, valid and parity error, all zero when no access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v1_r <= 1'b0;
      d1_r <= {DW{1'b0}};
      p1_r <= {NB{1'b0}};
    end else begin
      v1_r <= acc_s;
      d1_r <= acc_s ? rd_word_s : {DW{1'b0}};
      p1_r <= acc_s ? rd_perr_s : {NB{1'b0}};
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic          v2_r;
      logic [DW-1:0] d2_r;
      logic [NB-1:0] p2_r;

      // Optional second read stage for a 2-cycle read latency.
      always_ff @(posedge CLK) begin
        if (RST) begin
          v2_r <= 1'b0;
          d2_r <= {DW{1'b0}};
          p2_r <= {NB{1'b0}};
        end else begin
          v2_r <= v1_r;
          d2_r <= d1_r;
          p2_r <= p1_r;
        end
      end

      assign bus.RVALID = v2_r;
      assign bus.RDATA  = d2_r;
      assign bus.PERR   = p2_r;
    end else begin : g_noreg
      assign bus.RVALID = v1_r;
      assign bus.RDATA  = d1_r;
      assign bus.PERR   = p1_r;
    end
  endgenerate

  assign bus.BUSY = (state_r == ST_FILL);

endmodule

// File: tb/tb_cmsdk_fpga_sram_ext.sv
// Directed testbench for cmsdk_fpga_sram_ext.
// - Runs two instances (OREG=0 and OREG=1) side by side on the same stimulus.
// - AW=4, DW=32, INIT_CLEAR=1 for both.
module tb_cmsdk_fpga_sram_ext;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  cmsdk_fpga_sram_ext_if #(.AW(AW), .DW(DW)) bus0 ();
  cmsdk_fpga_sram_ext_if #(.AW(AW), .DW(DW)) bus1 ();

  assign bus1.ADDR  = bus0.ADDR;
  assign bus1.WDATA = bus0.WDATA;
  assign bus1.WREN  = bus0.WREN;
  assign bus1.CS    = bus0.CS;

  cmsdk_fpga_sram_ext #(.AW(AW), .DW(DW), .OREG(0), .INIT_CLEAR(1)) dut (
    .CLK(CLK), .RST(RST), .bus(bus0)
  );

  cmsdk_fpga_sram_ext #(.AW(AW), .DW(DW), .OREG(1), .INIT_CLEAR(1)) dut2 (
    .CLK(CLK), .RST(RST), .bus(bus1)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic cs, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] we);
    bus0.CS    = cs;
    bus0.ADDR  = a;
    bus0.WDATA = d;
    bus0.WREN  = we;
  endtask

  // Counts BUSY-high cycles starting from the current one, with a bounded wait.
  // Also watches that RVALID stays low during the fill.
  task automatic count_busy(input string name);
    int n;
    bit done;
    bit rv_seen;
    n = (bus0.BUSY === 1'b1) ? 1 : 0;
    done = 1'b0;
    rv_seen = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      if (bus0.RVALID !== 1'b0 || bus1.RVALID !== 1'b0) rv_seen = 1'b1;
      if (bus0.BUSY === 1'b1) n++;
      else done = 1'b1;
    end
    checks++;
    if (!done || n != 16) begin
      errors++;
      $display("FAIL %s busy_len: got %0d cycles (ended=%0b), expected 16", name, n, done);
    end
    checks++;
    if (rv_seen) begin
      errors++;
      $display("FAIL %s rvalid_in_fill: got 1, expected 0", name);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 4'd0, 32'h0, 4'h0);
    RST = 1'b1;
    step();
    step();
    checks++;
    if (bus0.RVALID !== 1'b0 || bus0.RDATA !== 32'h0 || bus0.PERR !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rv=%b rd=%h perr=%b, expected 0/00000000/0000", bus0.RVALID, bus0.RDATA, bus0.PERR);
    end
    checks++;
    if (bus0.BUSY !== 1'b1 || bus1.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got %b/%b, expected 1/1", bus0.BUSY, bus1.BUSY);
    end
    RST = 1'b0;
    count_busy("init");
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, a[AW-1:0], 32'h0, 4'h0);
      step();
      checks++;
      if (bus0.RVALID !== 1'b1 || bus0.RDATA !== 32'h0) begin
        errors++;
        $display("FAIL fill_zero[%0d]: got rv=%b rd=%h, expected 1/00000000", a, bus0.RVALID, bus0.RDATA);
      end
    end
    drive(1'b0, 4'd0, 32'h0, 4'h0);
    step();
  endtask

  task automatic test_lane_write();
    drive(1'b1, 4'd3, 32'h11223344, 4'hF);
    step();
    checks++;
    if (bus0.RDATA !== 32'h11223344) begin
      errors++;
      $display("FAIL full_write_rdw: got %h, expected 11223344", bus0.RDATA);
    end
    drive(1'b1, 4'd3, 32'hDEADBEEF, 4'b0101);
    step();
    checks++;
    if (bus0.RDATA !== 32'h11AD33EF) begin
      errors++;
      $display("FAIL lane_write_rdw: got %h, expected 11AD33EF", bus0.RDATA);
    end
    drive(1'b1, 4'd3, 32'h0, 4'h0);
    step();
    checks++;
    if (bus0.RVALID !== 1'b1 || bus0.RDATA !== 32'h11AD33EF) begin
      errors++;
      $display("FAIL lane_write_read: got rv=%b rd=%h, expected 1/11AD33EF", bus0.RVALID, bus0.RDATA);
    end
    drive(1'b0, 4'd0, 32'h0, 4'h0);
    step();
    step();
  endtask

  task automatic test_latency();
    int c0;
    int c1;
    drive(1'b1, 4'd3, 32'h0, 4'h0);
    step();
    drive(1'b0, 4'd0, 32'h0, 4'h0);
    checks++;
    if (bus0.RVALID !== 1'b1 || bus1.RVALID !== 1'b0) begin
      errors++;
      $display("FAIL latency_n1: got rv0=%b rv1=%b, expected 1/0", bus0.RVALID, bus1.RVALID);
    end
    step();
    checks++;
    if (bus0.RVALID !== 1'b0 || bus1.RVALID !== 1'b1 || bus1.RDATA !== 32'h11AD33EF) begin
      errors++;
      $display("FAIL latency_n2: got rv0=%b rv1=%b rd1=%h, expected 0/1/11AD33EF", bus0.RVALID, bus1.RVALID, bus1.RDATA);
    end
    step();
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b1, k[AW-1:0], 32'h0, 4'h0);
      else drive(1'b0, 4'd0, 32'h0, 4'h0);
      step();
      if (bus0.RVALID === 1'b1) c0++;
      if (bus1.RVALID === 1'b1) c1++;
      if (k == 4) begin
        checks++;
        if (bus1.RDATA !== 32'h11AD33EF) begin
          errors++;
          $display("FAIL stream_last_oreg1: got %h, expected 11AD33EF", bus1.RDATA);
        end
      end
    end
    checks++;
    if (c0 != 4 || c1 != 4) begin
      errors++;
      $display("FAIL stream_count: got %0d/%0d, expected 4/4", c0, c1);
    end
  endtask

  task automatic test_rdw();
    drive(1'b1, 4'd5, 32'hCAFEF00D, 4'hF);
    step();
    checks++;
    if (bus0.RVALID !== 1'b1 || bus0.RDATA !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rdw_same_cycle: got rv=%b rd=%h, expected 1/CAFEF00D", bus0.RVALID, bus0.RDATA);
    end
    drive(1'b0, 4'd5, 32'h0, 4'bxxxx);
    step();
    checks++;
    if (bus0.RVALID !== 1'b0 || bus0.RDATA !== 32'h0) begin
      errors++;
      $display("FAIL cs_low: got rv=%b rd=%h, expected 0/00000000", bus0.RVALID, bus0.RDATA);
    end
    drive(1'b1, 4'd5, 32'h0, 4'h0);
    step();
    drive(1'b1, 4'd5, 32'h12345678, 4'hF);
    checks++;
    if (bus0.RDATA !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL x_wren_no_write: got %h, expected CAFEF00D", bus0.RDATA);
    end
    step();
    drive(1'b0, 4'd0, 32'h0, 4'h0);
    checks++;
    if (bus0.RDATA !== 32'h12345678 || bus1.RDATA !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL write_after_read: got rd0=%h rd1=%h, expected 12345678/CAFEF00D", bus0.RDATA, bus1.RDATA);
    end
    step();
    step();
  endtask

  task automatic test_parity();
    drive(1'b1, 4'd9, 32'h01020304, 4'hF);
    step();
    drive(1'b0, 4'd0, 32'h0, 4'h0);
    step();
`ifdef CMSDK_FPGA_SRAM_PARITY_EN
    dut.par_r[9][2] = ~dut.par_r[9][2];
    drive(1'b1, 4'd9, 32'h0, 4'h0);
    step();
    drive(1'b0, 4'd0, 32'h0, 4'h0);
    checks++;
    if (bus0.PERR !== 4'b0100 || bus0.RDATA !== 32'h01020304) begin
      errors++;
      $display("FAIL parity_flip: got perr=%b rd=%h, expected 0100/01020304", bus0.PERR, bus0.RDATA);
    end
`else
    drive(1'b1, 4'd9, 32'h0, 4'h0);
    step();
    drive(1'b0, 4'd0, 32'h0, 4'h0);
    checks++;
    if (bus0.PERR !== 4'b0000 || bus0.RDATA !== 32'h01020304) begin
      errors++;
      $display("FAIL parity_off: got perr=%b rd=%h, expected 0000/01020304", bus0.PERR, bus0.RDATA);
    end
`endif
    step();
    checks++;
    if (bus0.PERR !== 4'b0000) begin
      errors++;
      $display("FAIL perr_masked: got %b, expected 0000", bus0.PERR);
    end
  endtask

  task automatic test_reset_fill();
    drive(1'b1, 4'd5, 32'h0, 4'h0);
    step();
    RST = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 4'h0);
    step();
    checks++;
    if (bus1.RVALID !== 1'b0 || bus1.RDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_read: got rv=%b rd=%h, expected 0/00000000", bus1.RVALID, bus1.RDATA);
    end
    RST = 1'b0;
    for (int k = 0; k < 7; k++) step();
    RST = 1'b1;
    drive(1'b1, 4'd5, 32'hFFFFFFFF, 4'hF);
    step();
    checks++;
    if (bus0.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL busy_at_rst: got %b, expected 1", bus0.BUSY);
    end
    RST = 1'b0;
    count_busy("refill");
    drive(1'b0, 4'd0, 32'h0, 4'h0);
    step();
    drive(1'b1, 4'd5, 32'h0, 4'h0);
    step();
    checks++;
    if (bus0.RVALID !== 1'b1 || bus0.RDATA !== 32'h0) begin
      errors++;
      $display("FAIL fill_no_user_write: got rv=%b rd=%h, expected 1/00000000", bus0.RVALID, bus0.RDATA);
    end
    drive(1'b1, 4'd9, 32'h0, 4'h0);
    step();
    drive(1'b0, 4'd0, 32'h0, 4'h0);
    checks++;
    if (bus0.RDATA !== 32'h0) begin
      errors++;
      $display("FAIL refill_addr9: got %h, expected 00000000", bus0.RDATA);
    end
    step();
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 4'h0);
    test_reset();
    test_lane_write();
    test_latency();
    test_rdw();
    test_parity();
    test_reset_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
